mem_bist: RTL and testbench

Memory built-in self-test initiator. It drives the memory block's request interface (address, write data, read/write enables) and consumes its read data. It runs a 4-phase March sequence over a configurable word range starting at BASE_ADDR. It reports pass/fail, and on failure captures the first failing address, the observed data and the expected data. It sits between the memory and the top-level test/debug logic and is the initiator counterpart of the memory.

---
 rtl/mem_bist_pkg.sv | 48 ++++
 rtl/mem_bist.sv | 176 +++++++++++++++++
 tb/tb_mem_bist.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bist_pkg.sv
// Shared types and pattern helpers for the March-style memory BIST initiator.
package mem_bist_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_W_BG,
        S_RW1_RD,
        S_RW1_CK,
        S_RW2_RD,
        S_RW2_CK,
        S_R_RD,
        S_R_CK,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        PH_NONE,
        PH_BG,
        PH_RW1,
        PH_RW2,
        PH_R
    } phase_e;

    // Patterns are built at this width and narrowed by the caller to its data width.
    localparam int unsigned PAT_MAXW = 64;
    typedef logic [PAT_MAXW-1:0] pat_t;

    function automatic phase_e state_phase(state_e s);
        phase_e ph;
        case (s)
            S_W_BG:             ph = PH_BG;
            S_RW1_RD, S_RW1_CK: ph = PH_RW1;
            S_RW2_RD, S_RW2_CK: ph = PH_RW2;
            S_R_RD, S_R_CK:     ph = PH_R;
            default:            ph = PH_NONE;
        endcase
        return ph;
    endfunction

    function automatic pat_t pat_bg(pat_t seed, pat_t idx);
        return seed ^ idx;
    endfunction

    function automatic pat_t pat_inv(pat_t seed, pat_t idx);
        return ~pat_bg(seed, idx);
    endfunction

endpackage

// File: rtl/mem_bist.sv
// Memory BIST initiator: background write, ascending read/invert, descending
// read/restore, ascending read-only; stops and captures at the first mismatch.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start_i
// W_BG     | write P(i), ascending
// RW1_RD   | read word i (ascending pass)
// RW1_CK   | expect P(i); on match write Q(i)
// RW2_RD   | read word i (descending pass)
// RW2_CK   | expect Q(i); on match write P(i)
// R_RD     | read word i (final ascending pass)
// R_CK     | expect P(i), no write
// DONE     | result held until start_i or rst
module mem_bist
    import mem_bist_pkg::*;
#(
    parameter int unsigned        AWIDTH    = 32,
    parameter int unsigned        DWIDTH    = 32,
    parameter logic [AWIDTH-1:0]  BASE_ADDR = AWIDTH'(32'h0100_0000),
    parameter int unsigned        NUM_WORDS = 16,
    parameter int unsigned        ADDR_STEP = 4,
    parameter logic [DWIDTH-1:0]  PATTERN   = DWIDTH'(32'hA5A5_5A5A)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic [AWIDTH-1:0] addr_o,
    output logic [DWIDTH-1:0] data_o,
    output logic              read_en_o,
    output logic              write_en_o,
    input  logic [DWIDTH-1:0] data_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              pass_o,
    output logic [AWIDTH-1:0] fail_addr_o,
    output logic [DWIDTH-1:0] fail_data_o,
    output logic [DWIDTH-1:0] fail_exp_o
);

    localparam int unsigned   IW       = (NUM_WORDS > 2) ? $clog2(NUM_WORDS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_WORDS - 1);

    state_e              state_q, state_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic                err_q, err_d;
    logic                done_q, done_d;
    logic                pass_q, pass_d;
    logic [AWIDTH-1:0]   fail_addr_q, fail_addr_d;
    logic [DWIDTH-1:0]   fail_data_q, fail_data_d;
    logic [DWIDTH-1:0]   fail_exp_q, fail_exp_d;

    phase_e              phase;
    logic [DWIDTH-1:0]   pat_p, pat_q, exp_data, wr_data;
    logic [AWIDTH-1:0]   addr_cur;
    logic                is_rd, is_ck, match, rd_en, wr_en;

    always_comb begin
        phase    = state_phase(state_q);
        pat_p    = DWIDTH'(pat_bg(PAT_MAXW'(PATTERN), PAT_MAXW'(idx_q)));
        pat_q    = DWIDTH'(pat_inv(PAT_MAXW'(PATTERN), PAT_MAXW'(idx_q)));
        addr_cur = BASE_ADDR + AWIDTH'(idx_q) * AWIDTH'(ADDR_STEP);
        exp_data = (phase == PH_RW2) ? pat_q : pat_p;
        wr_data  = (phase == PH_RW1) ? pat_q : pat_p;
        is_rd    = state_q inside {S_RW1_RD, S_RW2_RD, S_R_RD};
        is_ck    = state_q inside {S_RW1_CK, S_RW2_CK, S_R_CK};
        // Written as a guarded set so an unknown compare result falls to mismatch.
        match    = 1'b0;
        if (data_i == exp_data) begin
            match = 1'b1;
        end
        rd_en    = is_rd;
        wr_en    = (state_q == S_W_BG) || (is_ck && match && (phase != PH_R));
    end

    assign read_en_o   = rd_en;
    assign write_en_o  = wr_en;
    assign addr_o      = (rd_en || wr_en) ? addr_cur : '0;
    assign data_o      = wr_en ? wr_data : '0;
    assign busy_o      = !(state_q inside {S_IDLE, S_DONE});
    assign done_o      = done_q;
    assign pass_o      = pass_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_data_o = fail_data_q;
    assign fail_exp_o  = fail_exp_q;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        err_d       = err_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;
        fail_exp_d  = fail_exp_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d     = S_W_BG;
                    idx_d       = '0;
                    err_d       = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    fail_exp_d  = '0;
                end
            end
            S_W_BG: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_RW1_RD;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            S_RW1_RD: state_d = S_RW1_CK;
            S_RW1_CK: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_RW2_RD;
                end else begin
                    state_d = S_RW1_RD;
                    idx_d   = idx_q + 1'b1;
                end
            end
            S_RW2_RD: state_d = S_RW2_CK;
            S_RW2_CK: begin
                if (idx_q == '0) begin
                    state_d = S_R_RD;
                end else begin
                    state_d = S_RW2_RD;
                    idx_d   = idx_q - 1'b1;
                end
            end
            S_R_RD: state_d = S_R_CK;
            S_R_CK: begin
                if (idx_q == LAST_IDX) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_R_RD;
                    idx_d   = idx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (is_ck && !match) begin
            state_d     = S_DONE;
            err_d       = 1'b1;
            fail_addr_d = addr_cur;
            fail_data_d = data_i;
            fail_exp_d  = exp_data;
        end
        // Result flags follow the DONE state by one cycle and drop on restart.
        done_d = (state_q == S_DONE) && !start_i;
        pass_d = done_d && !err_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            err_q       <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
            fail_exp_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            err_q       <= err_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
            fail_exp_q  <= fail_exp_d;
        end
    end

endmodule

// File: tb/tb_mem_bist.sv
// Directed bench for mem_bist: behavioural 1-cycle memory with optional
// stuck-at / alias faults and a request scoreboard.
module tb_mem_bist;

    localparam int          N    = 16;
    localparam logic [31:0] BASE = 32'h0100_0000;
    localparam logic [31:0] PAT  = 32'hA5A5_5A5A;

    logic        clk = 1'b0;
    logic        rst, start_i;
    logic [31:0] addr_o, data_o, data_i;
    logic        read_en_o, write_en_o, busy_o, done_o, pass_o;
    logic [31:0] fail_addr_o, fail_data_o, fail_exp_o;

    always #5 clk = ~clk;

    mem_bist #(
        .AWIDTH(32), .DWIDTH(32), .BASE_ADDR(BASE),
        .NUM_WORDS(N), .ADDR_STEP(4), .PATTERN(PAT)
    ) dut (
        .clk(clk), .rst(rst), .start_i(start_i),
        .addr_o(addr_o), .data_o(data_o),
        .read_en_o(read_en_o), .write_en_o(write_en_o),
        .data_i(data_i), .busy_o(busy_o), .done_o(done_o), .pass_o(pass_o),
        .fail_addr_o(fail_addr_o), .fail_data_o(fail_data_o), .fail_exp_o(fail_exp_o)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    int          checks = 0;
    int          errors = 0;
    int          fault_mode = 0;
    bit          sb_on = 1'b0;
    int          n_rd, n_wr;
    int          cyc_cnt = 0;
    int          t_start;
    int          lat;
    txn_t        sb_q[$];
    txn_t        mon_t;
    logic [31:0] rd_log[$];
    logic [31:0] mem[N];
    logic [31:0] rdata = '0;

    assign data_i = rdata;

    function automatic logic [31:0] p_of(int i);
        return PAT ^ 32'(i);
    endfunction

    function automatic logic [31:0] a_of(int i);
        return BASE + 32'(i) * 32'd4;
    endfunction

    function automatic int cell_of(logic [31:0] a);
        int w;
        w = int'((a - BASE) >> 2);
        if (w < 0 || w >= N) w = 0;
        if (fault_mode == 2 && w == 11) w = 3;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: write lands at the edge, read data valid the cycle after read_en_o.
    always @(posedge clk) begin
        cyc_cnt <= cyc_cnt + 1;
        if (write_en_o) mem[cell_of(addr_o)] <= data_o;
        if (read_en_o)
            rdata <= mem[cell_of(addr_o)] |
                     ((fault_mode == 1 && cell_of(addr_o) == 5) ? 32'd1 : 32'd0);
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (read_en_o || write_en_o) begin
                chk("rw_excl", 64'(read_en_o & write_en_o), 64'd0);
                if (sb_on) begin
                    if (write_en_o) n_wr++;
                    else begin
                        n_rd++;
                        rd_log.push_back(addr_o);
                    end
                    chk("sb_nonempty", 64'(sb_q.size() != 0), 64'd1);
                    if (sb_q.size() != 0) begin
                        mon_t = sb_q.pop_front();
                        chk("sb_kind", 64'(write_en_o), 64'(mon_t.wr));
                        chk("sb_addr", 64'(addr_o), 64'(mon_t.addr));
                        chk("sb_data", 64'(data_o), 64'(mon_t.data));
                    end
                end
            end else begin
                chk("idle_bus", {addr_o, data_o}, 64'd0);
            end
        end
    end

    task automatic push_expected();
        txn_t t;
        sb_q.delete();
        rd_log.delete();
        n_rd = 0;
        n_wr = 0;
        for (int i = 0; i < N; i++) begin
            t.wr = 1'b1; t.addr = a_of(i); t.data = p_of(i); sb_q.push_back(t);
        end
        for (int i = 0; i < N; i++) begin
            t.wr = 1'b0; t.addr = a_of(i); t.data = '0;       sb_q.push_back(t);
            t.wr = 1'b1; t.addr = a_of(i); t.data = ~p_of(i); sb_q.push_back(t);
        end
        for (int i = N - 1; i >= 0; i--) begin
            t.wr = 1'b0; t.addr = a_of(i); t.data = '0;       sb_q.push_back(t);
            t.wr = 1'b1; t.addr = a_of(i); t.data = p_of(i);  sb_q.push_back(t);
        end
        for (int i = 0; i < N; i++) begin
            t.wr = 1'b0; t.addr = a_of(i); t.data = '0;       sb_q.push_back(t);
        end
    endtask

    task automatic do_start();
        start_i = 1'b1;
        @(posedge clk);
        #1;
        start_i = 1'b0;
        t_start = cyc_cnt;
    endtask

    task automatic wait_done(output int latency);
        while (!done_o && (cyc_cnt - t_start) < 400) begin
            @(posedge clk);
            #1;
        end
        latency = cyc_cnt - t_start;
        chk("done_seen", 64'(done_o), 64'd1);
    endtask

    task automatic check_clean_run(input int latency);
        chk("latency", 64'(latency), 64'd113);
        chk("pass", 64'(pass_o), 64'd1);
        chk("busy_done", 64'(busy_o), 64'd0);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("n_wr", 64'(n_wr), 64'd48);
        chk("n_rd", 64'(n_rd), 64'd48);
        chk("fail_addr_clean", 64'(fail_addr_o), 64'd0);
    endtask

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", 64'(addr_o), 64'd0);
        chk("rst_data", 64'(data_o), 64'd0);
        chk("rst_en", 64'({read_en_o, write_en_o}), 64'd0);
        chk("rst_status", 64'({busy_o, done_o, pass_o}), 64'd0);
        chk("rst_fail", {fail_addr_o, fail_data_o | fail_exp_o}, 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Clean run
        push_expected();
        sb_on = 1'b1;
        do_start();
        chk("busy_run", 64'(busy_o), 64'd1);
        wait_done(lat);
        sb_on = 1'b0;
        check_clean_run(lat);
        for (int i = 0; i < N; i++) chk("mem_final", 64'(mem[i]), 64'(p_of(i)));
        chk("rd_log_len", 64'(rd_log.size()), 64'd48);
        if (rd_log.size() == 48)
            for (int k = 0; k < N; k++) chk("ph3_desc", 64'(rd_log[16 + k]), 64'(a_of(N - 1 - k)));

        // Word 5 bit 0 stuck at 1: P(5) already has bit 0 set, so Q(5) trips in phase 3
        fault_mode = 1;
        do_start();
        wait_done(lat);
        chk("stuck_pass", 64'(pass_o), 64'd0);
        chk("stuck_addr", 64'(fail_addr_o), 64'h0100_0014);
        chk("stuck_exp", 64'(fail_exp_o), 64'h5A5A_A5A0);
        chk("stuck_data", 64'(fail_data_o), 64'h5A5A_A5A1);

        // Words 3 and 11 alias: phase 2 reads P(11) at word 3
        fault_mode = 2;
        do_start();
        wait_done(lat);
        chk("alias_pass", 64'(pass_o), 64'd0);
        chk("alias_addr", 64'(fail_addr_o), 64'h0100_000C);
        chk("alias_exp", 64'(fail_exp_o), 64'hA5A5_5A59);
        chk("alias_data", 64'(fail_data_o), 64'hA5A5_5A51);

        // Restart from DONE after a failure, with start pulses while busy
        fault_mode = 0;
        push_expected();
        sb_on = 1'b1;
        do_start();
        chk("restart_done", 64'(done_o), 64'd0);
        chk("restart_pass", 64'(pass_o), 64'd0);
        chk("restart_fail", {fail_addr_o, fail_data_o | fail_exp_o}, 64'd0);
        chk("restart_busy", 64'(busy_o), 64'd1);
        for (int k = 0; k < 3; k++) begin
            repeat (20) @(posedge clk);
            #1;
            start_i = 1'b1;
            @(posedge clk);
            #1;
            start_i = 1'b0;
            chk("busy_ignore", 64'(busy_o), 64'd1);
        end
        wait_done(lat);
        sb_on = 1'b0;
        check_clean_run(lat);

        // Reset mid phase 2
        do_start();
        repeat (40) @(posedge clk);
        #1;
        chk("pre_rst_busy", 64'(busy_o), 64'd1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_en", 64'({read_en_o, write_en_o}), 64'd0);
        chk("abort_bus", {addr_o, data_o}, 64'd0);
        chk("abort_status", 64'({busy_o, done_o, pass_o}), 64'd0);
        chk("abort_fail", {fail_addr_o, fail_data_o | fail_exp_o}, 64'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_rst", 64'({busy_o, read_en_o, write_en_o}), 64'd0);

        push_expected();
        sb_on = 1'b1;
        do_start();
        wait_done(lat);
        sb_on = 1'b0;
        check_clean_run(lat);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
